uart_msg_seq: RTL and testbench

UART_MSG_SEQ -- requirements
Module: uart_msg_seq

---
 rtl/uart_msg_seq_pkg.sv | 25 ++
 rtl/uart_msg_seq_poll_timer.sv | 29 ++
 rtl/uart_msg_seq.sv | 169 ++++++++++++++++
 tb/tb_uart_msg_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_msg_seq_pkg.sv
// Shared definitions for the UART message sequencer: UART register map,
// status bit positions and the sequencer state encoding.
package uart_msg_seq_pkg;

  localparam logic [31:0] UART_STATUS_OFS = 32'd4;
  localparam logic [31:0] UART_TXDATA_OFS = 32'd12;

  localparam int UART_STAT_TX_BUSY_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACQ   = 3'd1,
    ST_POLL  = 3'd2,
    ST_WRITE = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } seq_state_e;

  function automatic logic [31:0] uart_reg_addr(input logic [31:0] base,
                                                input logic [31:0] ofs);
    return base + ofs;
  endfunction

endpackage

// File: rtl/uart_msg_seq_poll_timer.sv
// Saturating 16-bit count of busy status polls for the byte in flight.
// o_expired flags that the busy poll being counted this cycle is the POLL_MAX-th.
module poll_timer #(
  parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_sat,
  output logic o_expired
);

  logic [15:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != POLL_MAX)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_sat     = (r_count == POLL_MAX);
  assign o_expired = i_en && (r_count == (POLL_MAX - 16'd1));

endmodule

// File: rtl/uart_msg_seq.sv
// Takes the data bus from the core and writes MSG_LEN ROM bytes to a UART,
// polling its TX-busy bit before each byte and aborting on poll timeout.
module uart_msg_seq
  import uart_msg_seq_pkg::*;
#(
  parameter int          MSG_LEN   = 8,
  parameter logic [31:0] UART_BASE = 32'h30000000,
  parameter logic [15:0] POLL_MAX  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        ex_mem_req_i,
  output logic        hold_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic [7:0]  msg_idx_o,
  input  logic [7:0]  msg_byte_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  state_dbg_o
);

  // Bus handshake: a transfer happens in every cycle mem_req_o=1; the UART
  // answers reads combinationally in that cycle and there is no ready/stall.

  localparam logic [7:0]  LAST_IDX    = 8'(MSG_LEN - 1);
  localparam logic [31:0] STATUS_ADDR = uart_reg_addr(UART_BASE, UART_STATUS_OFS);
  localparam logic [31:0] TXDATA_ADDR = uart_reg_addr(UART_BASE, UART_TXDATA_OFS);

  seq_state_e  r_state;
  logic        r_hold;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [7:0]  r_idx;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic w_tx_busy;
  logic w_tmr_clr;
  logic w_tmr_en;
  logic w_tmr_sat;
  logic w_tmr_expired;
  logic w_unused_rdata;

  assign w_tx_busy      = mem_rdata_i[UART_STAT_TX_BUSY_BIT];
  assign w_unused_rdata = ^mem_rdata_i;
  assign w_tmr_en       = (r_state == ST_POLL) && w_tx_busy;
  assign w_tmr_clr      = (r_state == ST_NEXT) || ((r_state == ST_IDLE) && start_i);

  poll_timer #(
    .POLL_MAX (POLL_MAX)
  ) u_poll_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_sat     (w_tmr_sat),
    .o_expired (w_tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hold  <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state <= ST_ACQ;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_hold  <= 1'b1;
          end
        end
        ST_ACQ: begin
          // Wait for the core's in-flight access to drain before taking the bus.
          if (!ex_mem_req_i) begin
            r_state <= ST_POLL;
            r_req   <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= STATUS_ADDR;
            r_wdata <= '0;
          end
        end
        ST_POLL: begin
          if (!w_tx_busy) begin
            r_state <= ST_WRITE;
            r_req   <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= TXDATA_ADDR;
            r_wdata <= {24'h0, msg_byte_i};
          end else if (w_tmr_expired || w_tmr_sat) begin
            r_state <= ST_ERR;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b1;
          end
        end
        ST_WRITE: begin
          r_state <= ST_NEXT;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
          r_addr  <= '0;
          r_wdata <= '0;
        end
        ST_NEXT: begin
          // Re-poll after every write: the UART raises busy one cycle late.
          if (r_idx == LAST_IDX) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_state <= ST_POLL;
            r_req   <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= STATUS_ADDR;
            r_wdata <= '0;
          end
        end
        ST_DONE, ST_ERR: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_hold  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_hold  <= 1'b0;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
          r_addr  <= '0;
          r_wdata <= '0;
        end
      endcase
    end
  end

  assign hold_o      = r_hold;
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign msg_idx_o   = r_idx;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign state_dbg_o = r_state;

endmodule

// File: tb/tb_uart_msg_seq.sv
// Bench for uart_msg_seq: a UART status responder with per-byte busy plans,
// a ROM array, and a timeline model of writes, polls and done/err cycles.
module tb_uart_msg_seq;

  localparam int          N    = 4;
  localparam logic [15:0] PM   = 16'd8;
  localparam logic [31:0] BASE = 32'h30000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, ex_mem_req_i;
  logic        hold_o, mem_req_o, mem_we_o, busy_o, done_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [7:0]  msg_idx_o, msg_byte_i;
  logic [2:0]  state_dbg_o;
  logic [7:0]  rom [256];

  logic        start1;
  logic        hold1, req1, we1, busy1, done1, err1;
  logic [31:0] addr1, wdata1;
  logic [7:0]  idx1, byte1;
  logic [2:0]  state1;

  always #5 clk = ~clk;

  assign msg_byte_i = rom[msg_idx_o];
  assign byte1      = rom[idx1];

  uart_msg_seq #(.MSG_LEN(N), .UART_BASE(BASE), .POLL_MAX(PM)) u_dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ex_mem_req_i(ex_mem_req_i),
    .hold_o(hold_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .msg_idx_o(msg_idx_o), .msg_byte_i(msg_byte_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .state_dbg_o(state_dbg_o)
  );

  uart_msg_seq #(.MSG_LEN(1), .UART_BASE(BASE)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .ex_mem_req_i(1'b0),
    .hold_o(hold1), .mem_req_o(req1), .mem_we_o(we1),
    .mem_addr_o(addr1), .mem_wdata_o(wdata1), .mem_rdata_i(32'h0),
    .msg_idx_o(idx1), .msg_byte_i(byte1), .busy_o(busy1),
    .done_o(done1), .err_o(err1), .state_dbg_o(state1)
  );

  int checks = 0;
  int errors = 0;

  int          cyc;
  logic [31:0] wr_q [$];
  logic [31:0] exp_q [$];
  int          done_cnt, done_cyc, err_cyc, poll_cnt, viol, hold_gap;
  int          busy_left, byte_k;
  int          busy_plan [N];
  logic        err_at1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe the cycle just started, then answer any status read.
  task automatic tick();
    logic busy_bit;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= 1 && done_cyc < 0 && err_cyc < 0 && (!hold_o || !busy_o)) hold_gap++;
    if (cyc == 1) err_at1 = err_o;
    if (!mem_req_o && (mem_we_o || mem_addr_o != 0 || mem_wdata_o != 0)) viol++;
    if (mem_req_o && !hold_o) viol++;
    if (mem_req_o && !((!mem_we_o && mem_addr_o == BASE + 4 && mem_wdata_o == 0) ||
                       (mem_we_o && mem_addr_o == BASE + 12 && mem_wdata_o[31:8] == 0))) viol++;
    mem_rdata_i = $urandom();
    if (mem_req_o && !mem_we_o) begin
      poll_cnt++;
      busy_bit = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      mem_rdata_i[0] = busy_bit;
    end
    if (mem_req_o && mem_we_o) begin
      wr_q.push_back(mem_wdata_o);
      byte_k++;
      busy_left = (byte_k < N) ? busy_plan[byte_k] : 0;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err_o && err_cyc < 0 && cyc >= 1) err_cyc = cyc;
  endtask

  task automatic clear_mon();
    wr_q.delete();
    done_cnt = 0; done_cyc = -1; err_cyc = -1;
    poll_cnt = 0; viol = 0; hold_gap = 0; byte_k = 0;
    err_at1 = 1'bx;
  endtask

  // a: ACQ stall cycles, ms: cycle of a stray start pulse (-1 for none)
  task automatic run_msg(input int a, input int ms, input string tag);
    int t, polls, exp_end;
    logic exp_err;
    t = 2 + a; polls = 0; exp_err = 1'b0;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      if (busy_plan[k] >= int'(PM)) begin
        polls += int'(PM); t += int'(PM); exp_err = 1'b1;
        break;
      end
      exp_q.push_back({24'h0, rom[k]});
      polls += busy_plan[k] + 1;
      t += busy_plan[k] + 3;
    end
    exp_end = t;

    clear_mon();
    busy_left = busy_plan[0];
    cyc = 0;
    start_i = 1'b1;
    while (done_cyc < 0 && err_cyc < 0 && cyc < 2000) begin
      tick();
      start_i      = (cyc == ms);
      ex_mem_req_i = (cyc >= 1 && cyc <= a);
    end
    start_i = 1'b0;
    ex_mem_req_i = 1'b0;
    tick();
    tick();

    chk({tag, " err_clr_on_start"}, {31'h0, err_at1}, 32'h0);
    chk({tag, " n_writes"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      chk($sformatf("%s wdata%0d", tag, i), wr_q[i], exp_q[i]);
    chk({tag, " n_polls"}, poll_cnt, polls);
    chk({tag, " end_cycle"}, exp_err ? err_cyc : done_cyc, exp_end);
    chk({tag, " done_pulses"}, done_cnt, exp_err ? 0 : 1);
    chk({tag, " bus_rules"}, viol, 0);
    chk({tag, " hold_busy_gap"}, hold_gap, 0);
    chk({tag, " idle_flags"}, {29'h0, busy_o, hold_o, err_o}, {31'h0, exp_err});
  endtask

  initial begin
    int found, nwr, dcyc;
    logic [31:0] wd1;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom());
    rom[0] = 8'h41; rom[1] = 8'h42; rom[2] = 8'h43; rom[3] = 8'h44;
    rst = 1'b1; start_i = 1'b0; ex_mem_req_i = 1'b0; start1 = 1'b0;
    mem_rdata_i = 32'h0;
    cyc = 0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {hold_o, mem_req_o, mem_we_o, busy_o, done_o, err_o, 2'b0, msg_idx_o, 16'h0},
        32'h0);
    chk("reset_bus", mem_addr_o | mem_wdata_o, 32'h0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < N; k++) busy_plan[k] = 0;
    run_msg(0, -1, "abcd");
    chk("abcd latency", done_cyc, 2 + 3 * N);

    busy_plan[1] = 5;
    run_msg(0, -1, "busy5");
    busy_plan[1] = 0;

    run_msg(3, -1, "acq3");

    busy_plan[0] = 1000;
    run_msg(0, -1, "timeout");
    busy_plan[0] = 0;

    run_msg(0, -1, "after_err");
    run_msg(0, 6, "mid_start");

    // Reset while byte 2 is being written, then confirm nothing resumes.
    clear_mon();
    busy_left = 0;
    cyc = 0;
    start_i = 1'b1;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      tick();
      start_i = 1'b0;
      if (mem_req_o && mem_we_o && msg_idx_o == 8'd1) found = 1;
    end
    chk("rst found_write2", found, 1);
    rst = 1'b1;
    #1;
    chk("rst async_outputs", {hold_o, mem_req_o, mem_we_o, busy_o, done_o, err_o, 2'b0, msg_idx_o, 16'h0},
        32'h0);
    chk("rst async_bus", mem_addr_o | mem_wdata_o, 32'h0);
    tick();
    rst = 1'b0;
    clear_mon();
    repeat (5) tick();
    chk("rst no_resume", poll_cnt + wr_q.size() + {31'h0, busy_o}, 0);
    run_msg(0, -1, "after_rst");

    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < N; k++) begin
        rom[k] = 8'($urandom());
        busy_plan[k] = $urandom_range(0, (it == 5) ? 9 : 6);
      end
      run_msg($urandom_range(0, 3), $urandom_range(1, 10), $sformatf("rnd%0d", it));
    end

    // Single-byte message on the MSG_LEN=1 instance.
    nwr = 0; dcyc = -1; wd1 = 32'h0;
    start1 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      start1 = 1'b0;
      if (req1 && we1) begin
        nwr++;
        wd1 = wdata1;
      end
      if (done1) dcyc = c;
    end
    chk("len1 n_writes", nwr, 1);
    chk("len1 wdata", wd1, {24'h0, rom[0]});
    chk("len1 done_cycle", dcyc, 5);
    chk("len1 idle", {29'h0, busy1, hold1, err1}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
